// File: rtl/if_stage.sv
// Instruction fetch stage with PC, IMEM handshake and IF/ID register.
// Ports: CLK/RESET, STALL, BRANCH_*, IMEM_* handshake, PC, IF_ID_*, FETCH_BUSY.
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDRESS,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_INSTRUCTION,
  output logic        IF_ID_VALID,
  output logic        FETCH_BUSY
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] hb_pc_q, hb_pc_d;
  logic [31:0] hb_ins_q, hb_ins_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_ins_q, ifid_ins_d;
  logic        ifid_vld_q, ifid_vld_d;
  logic        bubble;

  assign IMEM_READ         = !RESET && (state_q != HOLD);
  assign IMEM_ADDRESS      = pc_q;
  assign FETCH_BUSY        = IMEM_READ & IMEM_BUSYWAIT;
  assign PC                = pc_q;
  assign IF_ID_PC          = ifid_pc_q;
  assign IF_ID_INSTRUCTION = ifid_ins_q;
  assign IF_ID_VALID       = ifid_vld_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_d    = redir_q;
    hb_pc_d    = hb_pc_q;
    hb_ins_d   = hb_ins_q;
    ifid_pc_d  = ifid_pc_q;
    ifid_ins_d = ifid_ins_q;
    ifid_vld_d = ifid_vld_q;
    bubble     = 1'b0;
    case (state_q)
      FETCH: begin
        if (BRANCH_TAKEN) begin
          bubble = 1'b1;
          if (IMEM_BUSYWAIT) begin
            // Keep the request stable; apply the target once it retires.
            redir_d = BRANCH_TARGET;
            state_d = DISCARD;
          end else begin
            pc_d = BRANCH_TARGET;
          end
        end else if (!IMEM_BUSYWAIT) begin
          pc_d = pc_q + 32'd4;
          if (STALL) begin
            hb_pc_d  = pc_q;
            hb_ins_d = IMEM_READDATA;
            state_d  = HOLD;
          end else begin
            ifid_pc_d  = pc_q;
            ifid_ins_d = IMEM_READDATA;
            ifid_vld_d = 1'b1;
          end
        end else if (!STALL) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        if (BRANCH_TAKEN) begin
          bubble  = 1'b1;
          pc_d    = BRANCH_TARGET;
          state_d = FETCH;
        end else if (!STALL) begin
          ifid_pc_d  = hb_pc_q;
          ifid_ins_d = hb_ins_q;
          ifid_vld_d = 1'b1;
          state_d    = FETCH;
        end
      end
      DISCARD: begin
        bubble = !STALL || BRANCH_TAKEN;
        if (BRANCH_TAKEN) redir_d = BRANCH_TARGET;
        if (!IMEM_BUSYWAIT) begin
          pc_d    = BRANCH_TAKEN ? BRANCH_TARGET : redir_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    if (bubble) begin
      ifid_ins_d = NOP_INSTR;
      ifid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= FETCH;
      pc_q       <= RESET_VECTOR;
      redir_q    <= 32'd0;
      hb_pc_q    <= 32'd0;
      hb_ins_q   <= 32'd0;
      ifid_pc_q  <= 32'd0;
      ifid_ins_q <= NOP_INSTR;
      ifid_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_q    <= redir_d;
      hb_pc_q    <= hb_pc_d;
      hb_ins_q   <= hb_ins_d;
      ifid_pc_q  <= ifid_pc_d;
      ifid_ins_q <= ifid_ins_d;
      ifid_vld_q <= ifid_vld_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Random + directed bench for if_stage against a queue-based fetch model.
// Model tracks PC, a pending-redirect slot and a FIFO of buffered words.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET, STALL, BRANCH_TAKEN, IMEM_BUSYWAIT;
  logic [31:0] BRANCH_TARGET, IMEM_READDATA, IMEM_ADDRESS;
  logic        IMEM_READ, IF_ID_VALID, FETCH_BUSY;
  logic [31:0] PC, IF_ID_PC, IF_ID_INSTRUCTION;

  int errors = 0;
  int checks = 0;

  if_stage dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL),
    .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
    .IMEM_ADDRESS(IMEM_ADDRESS), .IMEM_READ(IMEM_READ),
    .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .PC(PC), .IF_ID_PC(IF_ID_PC),
    .IF_ID_INSTRUCTION(IF_ID_INSTRUCTION), .IF_ID_VALID(IF_ID_VALID),
    .FETCH_BUSY(FETCH_BUSY)
  );

  always #5 CLK = ~CLK;

  // reference model
  logic [31:0] m_pc, m_redir, m_ipc, m_ins;
  logic        m_vld, m_disc, m_redir_ok;
  logic [63:0] m_buf[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_flush();
    m_ins = NOP;
    m_vld = 1'b0;
  endtask

  task automatic m_edge(input logic r, s, b, input logic [31:0] t,
                        input logic bw);
    if (r) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_ins = NOP; m_vld = 1'b0;
      m_disc = 1'b0; m_buf.delete();
    end else if (m_buf.size() != 0) begin
      if (b) begin
        m_buf.delete(); m_pc = t; m_flush();
      end else if (!s) begin
        {m_ipc, m_ins} = m_buf.pop_front(); m_vld = 1'b1;
      end
    end else if (m_disc) begin
      if (b) m_redir = t;
      if (!bw) begin m_pc = m_redir; m_disc = 1'b0; end
      if (!s || b) m_flush();
    end else if (b) begin
      m_flush();
      if (bw) begin m_disc = 1'b1; m_redir = t; end
      else m_pc = t;
    end else if (!bw) begin
      if (s) m_buf.push_back({m_pc, mem(m_pc)});
      else begin m_ipc = m_pc; m_ins = mem(m_pc); m_vld = 1'b1; end
      m_pc = m_pc + 32'd4;
    end else if (!s) begin
      m_flush();
    end
  endtask

  // One cycle: drive at negedge, check request, clock, check state.
  task automatic step(input logic r, s, b, input logic [31:0] t,
                      input logic bw);
    logic exp_rd;
    @(negedge CLK);
    RESET = r; STALL = s; BRANCH_TAKEN = b;
    BRANCH_TARGET = t; IMEM_BUSYWAIT = bw;
    IMEM_READDATA = mem(IMEM_ADDRESS);
    #1;
    exp_rd = !r && m_buf.size() == 0;
    check("imem_read", {31'd0, IMEM_READ}, {31'd0, exp_rd});
    if (exp_rd) check("imem_addr", IMEM_ADDRESS, m_pc);
    check("fetch_busy", {31'd0, FETCH_BUSY}, {31'd0, exp_rd & bw});
    @(posedge CLK);
    m_edge(r, s, b, t, bw);
    #1;
    check("pc", PC, m_pc);
    check("valid", {31'd0, IF_ID_VALID}, {31'd0, m_vld});
    check("instr", IF_ID_INSTRUCTION, m_ins);
    if (m_vld || r) check("ifid_pc", IF_ID_PC, m_ipc);
  endtask

  task automatic go(input logic bw);
    step(1'b0, 1'b0, 1'b0, 32'h0, bw);
  endtask

  task automatic rst();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    RESET = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0;
    BRANCH_TARGET = 32'h0; IMEM_BUSYWAIT = 1'b0; IMEM_READDATA = 32'h0;
    m_pc = 0; m_redir = 0; m_ipc = 0; m_ins = NOP; m_vld = 0; m_disc = 0;
    m_redir_ok = 0;

    rst(); rst();
    check("rst_pc", PC, 32'h0);
    check("rst_ins", IF_ID_INSTRUCTION, NOP);
    repeat (4) go(1'b0);
    check("seq_pc", PC, 32'h10);
    check("seq_ifid_pc", IF_ID_PC, 32'hC);

    // busywait at PC=8
    rst(); go(1'b0); go(1'b0);
    repeat (3) begin
      go(1'b1);
      check("bw_addr", IMEM_ADDRESS, 32'h8);
      check("bw_vld", {31'd0, IF_ID_VALID}, 32'd0);
    end
    go(1'b0);
    check("bw_rel_pc", IF_ID_PC, 32'h8);
    check("bw_rel_ins", IF_ID_INSTRUCTION, mem(32'h8));

    // stall on the edge accepting PC=4
    rst(); go(1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("st_keep0", IF_ID_PC, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("st_keep1", IF_ID_PC, 32'h0);
    check("st_noread", {31'd0, IMEM_READ}, 32'd0);
    go(1'b0);
    check("st_rel", IF_ID_PC, 32'h4);
    check("st_pc", PC, 32'h8);

    // redirect while busy
    rst();
    step(1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
    go(1'b1); go(1'b1);
    check("dis_addr", IMEM_ADDRESS, 32'h20);
    go(1'b0);
    check("dis_pc", PC, 32'h100);
    check("dis_vld", {31'd0, IF_ID_VALID}, 32'd0);
    go(1'b0);
    check("dis_next", IF_ID_PC, 32'h100);

    // wrap and branch+stall
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    go(1'b0);
    check("wrap_pc", PC, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0202, 1'b0);
    check("bs_vld", {31'd0, IF_ID_VALID}, 32'd0);
    check("bs_ins", IF_ID_INSTRUCTION, NOP);
    check("bs_pc", PC, 32'h0000_0202);

    // reset during DISCARD
    go(1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h400, 1'b1);
    rst();
    check("rd_pc", PC, 32'h0);
    check("rd_vld", {31'd0, IF_ID_VALID}, 32'd0);
    go(1'b0);
    check("rd_fresh", IF_ID_PC, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, s, b, bw;
      logic [31:0] t;
      r  = ($urandom_range(99) == 0);
      s  = ($urandom_range(3) == 0);
      b  = ($urandom_range(9) == 0);
      bw = ($urandom_range(2) == 0);
      case ($urandom_range(3))
        0: t = 32'hFFFF_FFF8;
        1: t = $urandom;
        default: t = {$urandom_range(255), 2'b00};
      endcase
      step(r, s, b, t, bw);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
